// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: operand/hazard bus between the pipeline and the hazard controller.
//   D_rs/D_rt        D-stage source register addresses
//   D_rs/rt_tuse     cycles until each source is consumed (3 = unused)
//   D_md             D instruction touches HI/LO or is mult/div
//   E_wa/E_tnew      E-stage destination and result readiness
//   M_wa/M_tnew      M-stage destination and result readiness
//   E_md_start/div   mult/div issue pulse in E and its kind (1 = div)
//   PCE_F/DE_D       fetch PC enable and F/D register enable
//   FLUSH_E          D/E register clear (bubble insert)
//   md_busy          mult/div unit busy
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if;
   logic [4:0] D_rs;
   logic [4:0] D_rt;
   logic [1:0] D_rs_tuse;
   logic [1:0] D_rt_tuse;
   logic       D_md;
   logic [4:0] E_wa;
   logic [1:0] E_tnew;
   logic [4:0] M_wa;
   logic [1:0] M_tnew;
   logic       E_md_start;
   logic       E_md_div;
   logic       PCE_F;
   logic       DE_D;
   logic       FLUSH_E;
   logic       md_busy;

   modport master (
      output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_md,
      output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
      input  PCE_F, DE_D, FLUSH_E, md_busy
   );

   modport slave (
      input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_md,
      input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
      output PCE_F, DE_D, FLUSH_E, md_busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage core.
//   Compares D-stage sources (Tuse) against E/M destinations (Tnew), tracks the
//   multi-cycle mult/div unit with a busy countdown, and counts stalled cycles.
// Ports:
//   clk        system clock (rising edge)
//   reset      synchronous, active-high
//   bus        hazard_ctrl_if.slave (operand addresses, Tuse/Tnew, md control,
//              PCE_F / DE_D / FLUSH_E / md_busy outputs)
//   stall_cnt  saturating count of stalled cycles (CNT_W bits)
module hazard_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_if.slave     bus,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned RAW_W   = $clog2(MAX_LAT + 1);
   localparam int unsigned MD_W    = (RAW_W < 4) ? 4 : RAW_W;

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t       state_q, state_d;
   logic [MD_W-1:0] md_cnt_q, md_cnt_d;
   logic            md_busy;
   logic            stall_rs, stall_rt, stall_md, stall;

   // md FSM: state + countdown register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   // A start while BUSY is ignored; the countdown is not reloaded.
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.E_md_start) begin
               state_d  = BUSY;
               md_cnt_d = bus.E_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
            end
         end
         BUSY: begin
            if (md_cnt_q == MD_W'(1)) begin
               state_d  = IDLE;
               md_cnt_d = '0;
            end else begin
               md_cnt_d = md_cnt_q - MD_W'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            md_cnt_d = '0;
         end
      endcase
   end

   // Hazard detection; a Tnew of 0 can never exceed any Tuse, so it never stalls.
   always_comb begin
      md_busy  = (state_q == BUSY);
      stall_rs = (bus.D_rs != 5'd0) &&
                 (((bus.D_rs == bus.E_wa) && (bus.E_tnew > bus.D_rs_tuse)) ||
                  ((bus.D_rs == bus.M_wa) && (bus.M_tnew > bus.D_rs_tuse)));
      stall_rt = (bus.D_rt != 5'd0) &&
                 (((bus.D_rt == bus.E_wa) && (bus.E_tnew > bus.D_rt_tuse)) ||
                  ((bus.D_rt == bus.M_wa) && (bus.M_tnew > bus.D_rt_tuse)));
      // The issuing cycle itself also blocks a dependent md instruction.
      stall_md = bus.D_md && (md_busy || bus.E_md_start);
      stall    = stall_rs || stall_rt || stall_md;

      bus.md_busy = md_busy;
      bus.PCE_F   = ~stall;
      bus.DE_D    = ~stall;
      bus.FLUSH_E = stall;
   end

   // Saturating stall profiler
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
